// File: rtl/fetch_stage.sv
// Instruction fetch stage: fetch PC, single-outstanding imem handshake, IF/ID register.
// Optional direct-mapped BTB enabled with `define FETCH_BTB_EN.
module fetch_stage #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned BTB_ENTRIES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stallF,
  input  logic        stallD,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instrD,
  output logic [31:0] pcD,
  output logic [31:0] pcplus4D,
  output logic        validD,
  output logic        speculativeD,
  input  logic        btb_upd_valid,
  input  logic [31:0] btb_upd_pc,
  input  logic [31:0] btb_upd_target,
  input  logic        btb_upd_taken
);

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, DROP} state_t;

  state_t      state;
  logic [31:0] pc_f;
  logic [31:0] req_pc;
  logic        spec_pending;
  logic [31:0] skid_instr;
  logic [31:0] skid_pc;
  logic        skid_spec;

  logic        fire;
  logic [31:0] redir_pc;
  logic        btb_hit;
  logic [31:0] btb_target;
  logic [31:0] next_pc;

  assign imem_req  = (state == REQ) && !stallF;
  assign imem_addr = pc_f;
  assign fire      = imem_req && imem_gnt;
  assign redir_pc  = {redirect_pc[31:2], 2'b00};
  assign next_pc   = btb_hit ? btb_target : pc_f + 32'd4;

`ifdef FETCH_BTB_EN
  localparam int unsigned IDX_W = $clog2(BTB_ENTRIES);
  localparam int unsigned TAG_W = 30 - IDX_W;

  logic [BTB_ENTRIES-1:0] btb_valid;
  logic [TAG_W-1:0]       btb_tag [BTB_ENTRIES];
  logic [29:0]            btb_tgt [BTB_ENTRIES];

  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] up_tag;
  logic             unused_btb;

  assign lk_idx     = pc_f[2 +: IDX_W];
  assign lk_tag     = pc_f[31 -: TAG_W];
  assign up_idx     = btb_upd_pc[2 +: IDX_W];
  assign up_tag     = btb_upd_pc[31 -: TAG_W];
  assign btb_hit    = btb_valid[lk_idx] && (btb_tag[lk_idx] == lk_tag);
  assign btb_target = {btb_tgt[lk_idx], 2'b00};
  assign unused_btb = ^{btb_upd_pc[1:0], btb_upd_target[1:0], redirect_pc[1:0]};

  // Valid bits: install on taken, invalidate only when the tag matches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btb_valid <= '0;
    end else if (btb_upd_valid) begin
      if (btb_upd_taken) begin
        btb_valid[up_idx] <= 1'b1;
      end else if (btb_tag[up_idx] == up_tag) begin
        btb_valid[up_idx] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (btb_upd_valid && btb_upd_taken) begin
      btb_tag[up_idx] <= up_tag;
      btb_tgt[up_idx] <= btb_upd_target[31:2];
    end
  end
`else
  logic unused_btb;

  assign btb_hit    = 1'b0;
  assign btb_target = 32'h0000_0000;
  assign unused_btb = ^{btb_upd_valid, btb_upd_pc, btb_upd_target, btb_upd_taken,
                        redirect_pc[1:0]};
`endif

  // Fetch FSM, fetch PC, skid buffer and IF/ID register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      pc_f         <= RESET_PC;
      req_pc       <= RESET_PC;
      spec_pending <= 1'b0;
      skid_instr   <= NOP_INSTR;
      skid_pc      <= 32'h0000_0000;
      skid_spec    <= 1'b0;
      instrD       <= NOP_INSTR;
      pcD          <= 32'h0000_0000;
      pcplus4D     <= 32'h0000_0004;
      validD       <= 1'b0;
      speculativeD <= 1'b0;
    end else begin
      case (state)
        IDLE: state <= REQ;
        REQ: begin
          if (fire) begin
            state        <= redirect_valid ? DROP : WAIT;
            req_pc       <= pc_f;
            spec_pending <= btb_hit;
            pc_f         <= next_pc;
          end
        end
        WAIT: begin
          if (redirect_valid) begin
            state <= imem_rvalid ? REQ : DROP;
          end else if (imem_rvalid) begin
            state <= stallD ? HOLD : REQ;
            if (stallD) begin
              skid_instr <= imem_rdata;
              skid_pc    <= req_pc;
              skid_spec  <= spec_pending;
            end
          end
        end
        HOLD: begin
          if (redirect_valid || !stallD) state <= REQ;
        end
        DROP: begin
          if (imem_rvalid) state <= REQ;
        end
        default: state <= IDLE;
      endcase

      if (redirect_valid) pc_f <= redir_pc;

      // Redirect always bubbles IF/ID; otherwise stallD freezes it.
      if (redirect_valid) begin
        validD       <= 1'b0;
        instrD       <= NOP_INSTR;
        speculativeD <= 1'b0;
      end else if (!stallD) begin
        if (state == WAIT && imem_rvalid) begin
          validD       <= 1'b1;
          instrD       <= imem_rdata;
          pcD          <= req_pc;
          pcplus4D     <= req_pc + 32'd4;
          speculativeD <= spec_pending;
        end else if (state == HOLD) begin
          validD       <= 1'b1;
          instrD       <= skid_instr;
          pcD          <= skid_pc;
          pcplus4D     <= skid_pc + 32'd4;
          speculativeD <= skid_spec;
        end else begin
          validD       <= 1'b0;
          instrD       <= NOP_INSTR;
          speculativeD <= 1'b0;
        end
      end
    end
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction fetch stage: owns the fetch PC and the instruction-memory request/response handshake.
- Owns the IF/ID pipeline register that feeds decode.
- Consumes stallF/stallD from the hazard unit, plus branch/jump redirects resolved in execute.
- Produces speculativeD, which travels down the pipeline to become speculativeE/M/W at the hazard unit.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset
BTB_ENTRIES, 16, BTB depth (power of 2, ≥2); used only with FETCH_BTB_EN

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
stallF  in  1  hazard unit: hold fetch PC, issue no new request
stallD  in  1  hazard unit: hold IF/ID register
redirect_valid  in  1  execute resolved a mispredict/jump; flush IF/ID and refetch
redirect_pc  in  32  refetch target; bits [1:0] ignored (treated as 0)
imem_req  out  1  fetch request
imem_addr  out  32  fetch address (word aligned)
imem_gnt  in  1  request accepted this cycle (transfer on req&&gnt)
imem_rvalid  in  1  response data valid; ≥1 cycle after grant
imem_rdata  in  32  instruction word
instrD  out  32  IF/ID instruction
pcD  out  32  IF/ID PC
pcplus4D  out  32  pcD+4 (mod 2^32)
validD  out  1  IF/ID holds a real instruction
speculativeD  out  1  IF/ID instruction fetched down a predicted-taken path
btb_upd_valid  in  1  BTB update strobe from execute
btb_upd_pc  in  32  branch PC being updated
btb_upd_target  in  32  resolved target
btb_upd_taken  in  1  1 = install/overwrite entry; 0 = invalidate on tag match

Behaviour:
- Reset (async, rst_n=0):
  - pcF=RESET_PC, state=IDLE.
  - imem_req=0, imem_addr=RESET_PC.
  - instrD=32'h0000_0013 (NOP), pcD=0, pcplus4D=4, validD=0, speculativeD=0.
  - BTB valid bits cleared.
- Only one request is outstanding at a time. imem_req is combinational: (state==REQ) && !stallF. imem_addr=pcF. No stability rule: the request may be withdrawn before grant.
- States:
  - IDLE: first clock after reset release -> REQ.
  - REQ: on req&&gnt -> WAIT; pcF <= next PC (pcF+4, or BTB target on hit). spec_pending <= hit.
  - WAIT: on rvalid:
    - if !stallD: write response into IF/ID (validD=1, pcD=address of the granted request, speculativeD=spec_pending) -> REQ.
    - if stallD: capture into skid buffer -> HOLD.
  - HOLD: no request issued. When stallD=0, move buffer into IF/ID -> REQ.
  - DROP: the next rvalid is discarded -> REQ. Any redirect in DROP only updates pcF.
- IF/ID register:
  - stallD=1 and no redirect: holds its value.
  - stallD=0 with nothing arriving: loads a bubble (validD=0, instrD=NOP, speculativeD=0).
- Redirect (highest priority; overrides stallF/stallD):
  - IF/ID <= bubble next edge; pcF <= {redirect_pc[31:2],2'b00}.
  - REQ: stay REQ. If a grant occurs in the same cycle -> DROP.
  - WAIT: if rvalid in the same cycle, discard it -> REQ; otherwise -> DROP.
  - HOLD: buffer discarded -> REQ.
- Decode sees a fetched instruction at minimum 1 cycle after rvalid (registered). Best-case throughput is one instruction per 2 cycles with a 1-cycle memory (single outstanding request).
- stallF while in WAIT has no effect; the response is still accepted.
- PC arithmetic wraps modulo 2^32. 32'hFFFF_FFFC+4 = 0.

Optional Feature:
- Macro: FETCH_BTB_EN.
- With FETCH_BTB_EN:
  - Direct-mapped BTB, index = pc[2+:log2(BTB_ENTRIES)], tag = remaining upper PC bits, plus a valid bit.
  - Lookup uses pcF in REQ. A hit makes the next pcF the stored target and marks the instruction speculative.
  - Update is written on the clock edge. A lookup of the same index in the same cycle sees the old contents.
  - Update and redirect in the same cycle are independent.
- Without FETCH_BTB_EN:
  - No BTB storage; next PC is always pcF+4; speculativeD is constant 0.
  - btb_upd_* ports remain present and are ignored.

Test Plan:
- Reset release, memory always grants, rvalid 1 cycle later, rdata=addr^32'hA5A5_0000 -> pcD sequence 0,4,8,… with validD=1 every other cycle, instrD matching.
- stallD held 3 cycles while rvalid arrives for addr 8 -> state HOLD, no imem_req. On release, pcD=8, instrD correct. Next request addr 12.
- redirect_valid with redirect_pc=32'h0000_0102 while in WAIT (addr 16) -> addr-16 response discarded, validD=0 next edge, next imem_addr=32'h100.
- Redirect coinciding with rvalid, and redirect coinciding with grant -> the dropped response never reaches IF/ID; the next delivered pcD equals the redirect target.
- RESET_PC=32'hFFFF_FFF8 -> fetch addresses …FFF8, …FFFC, 0, 4; pcplus4D of …FFFC equals 0.
- FETCH_BTB_EN: update pc=0x20 target=0x80 taken; fetch 0x20 -> next imem_addr 0x80, speculativeD=1 on that instruction. Not-taken update, then refetch -> 0x24, speculativeD=0.
